asmd_multiplier_sm: RTL and testbench

//   Sequential shift-add (ASMD) multiplier, parametrised successor of the 4-bit unsigned unit.

---
 rtl/asmd_pkg.sv | 16 +
 rtl/asmd_mult_datapath.sv | 67 ++++++
 rtl/asmd_multiplier_sm.sv | 102 ++++++++++
 tb/tb_asmd_multiplier_sm.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/asmd_pkg.sv
// Shared definitions for the ASMD shift-add multiplier: FSM state encoding
// and the width rule for the step counter.
package asmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } asmd_state_e;

    // Counter must hold values 0..word_length.
    function automatic int asmd_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/asmd_mult_datapath.sv
// Datapath for the ASMD multiplier: operand magnitude capture, shift-add
// accumulation and final sign fix-up into the held product register.
module asmd_mult_datapath
    import asmd_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_load,
    input  logic           i_step,
    input  logic           i_fix,
    input  logic           i_signed_mode,
    input  logic [W-1:0]   i_word0,
    input  logic [W-1:0]   i_word1,
    input  logic [CW-1:0]  i_count,
    output logic           o_mplr_zero_next,
    output logic [2*W-1:0] o_product
);

    logic [W-1:0]   r_mcand;
    logic [W-1:0]   r_mplr;
    logic [2*W-1:0] r_acc;
    logic           r_neg;
    logic [2*W-1:0] r_product;

    logic [W-1:0]   w_mag0;
    logic [W-1:0]   w_mag1;
    logic [2*W-1:0] w_addend;
    logic [2*W-1:0] w_acc_next;
    logic [W-1:0]   w_mplr_next;

    // Magnitudes; the most-negative value maps to 2^(W-1), which still fits W bits.
    assign w_mag0 = (i_signed_mode && i_word0[W-1]) ? (~i_word0 + W'(1)) : i_word0;
    assign w_mag1 = (i_signed_mode && i_word1[W-1]) ? (~i_word1 + W'(1)) : i_word1;

    assign w_addend    = {{W{1'b0}}, r_mcand} << i_count;
    assign w_acc_next  = r_mplr[0] ? (r_acc + w_addend) : r_acc;
    assign w_mplr_next = r_mplr >> 1;

    // Lets the controller finish early once no multiplier bits remain.
    assign o_mplr_zero_next = (w_mplr_next == '0);
    assign o_product        = r_product;

    // Operand/accumulator registers and the visible product register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (i_load) begin
            r_mcand <= w_mag0;
            r_mplr  <= w_mag1;
            r_acc   <= '0;
            r_neg   <= i_signed_mode & (i_word0[W-1] ^ i_word1[W-1]);
        end else if (i_step) begin
            r_acc  <= w_acc_next;
            r_mplr <= w_mplr_next;
        end else if (i_fix) begin
            r_product <= r_neg ? (~r_acc + (2*W)'(1)) : r_acc;
        end
    end

endmodule

// File: rtl/asmd_multiplier_sm.sv
// Sequential shift-add multiplier, one operation in flight.
// Optional macro ASMD_EARLY_TERM_EN: leave RUN as soon as the remaining
// multiplier bits are all zero (results unchanged, shorter latency).
module asmd_multiplier_sm
    import asmd_pkg::*;
#(
    parameter int word_length = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [word_length-1:0]   word0,
    input  logic [word_length-1:0]   word1,
    input  logic                     signed_mode,
    output logic [2*word_length-1:0] product,
    output logic                     ready,
    output logic                     done
);

    localparam int CW = asmd_cnt_w(word_length);

    asmd_state_e r_state;
    asmd_state_e w_next_state;
    logic [CW-1:0] r_count;
    logic          r_done;
    logic          w_load;
    logic          w_step;
    logic          w_fix;
    logic          w_mplr_zero_next;
    logic          w_last_step;

    asmd_mult_datapath #(
        .W  (word_length),
        .CW (CW)
    ) u_dp (
        .clk              (clk),
        .reset            (reset),
        .i_load           (w_load),
        .i_step           (w_step),
        .i_fix            (w_fix),
        .i_signed_mode    (signed_mode),
        .i_word0          (word0),
        .i_word1          (word1),
        .i_count          (r_count),
        .o_mplr_zero_next (w_mplr_zero_next),
        .o_product        (product)
    );

`ifdef ASMD_EARLY_TERM_EN
    assign w_last_step = (r_count == CW'(word_length - 1)) || w_mplr_zero_next;
`else
    assign w_last_step = (r_count == CW'(word_length - 1));
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and datapath control.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last_step) w_next_state = ST_FIX;
            end
            ST_FIX: begin
                w_fix        = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Step counter: cleared on accept, advanced once per RUN edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_count <= '0;
        else if (w_load) r_count <= '0;
        else if (w_step) r_count <= r_count + CW'(1);
    end

    // Done pulses for the cycle following the edge that writes product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_done <= 1'b0;
        else       r_done <= w_fix;
    end

    assign ready = (r_state == ST_IDLE);
    assign done  = r_done;

endmodule

// File: tb/tb_asmd_multiplier_sm.sv
module tb_asmd_multiplier_sm;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   word0 = '0;
    logic [W-1:0]   word1 = '0;
    logic           signed_mode = 1'b0;
    logic [2*W-1:0] product;
    logic           ready;
    logic           done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [2*W-1:0] q_prod[$];
    int             q_lat[$];
    int             q_t0[$];

    asmd_multiplier_sm #(.word_length(W)) dut (
        .clk(clk), .reset(reset), .start(start), .word0(word0), .word1(word1),
        .signed_mode(signed_mode), .product(product), .ready(ready), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural reference: plain integer multiply of the interpreted operands.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        longint x, y, p;
        x = sm ? longint'($signed(a)) : longint'(a);
        y = sm ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[2*W-1:0];
    endfunction

    // Edges from accept to done (inclusive of FIX edge).
    function automatic int ref_lat(input logic [W-1:0] b, input logic sm);
`ifdef ASMD_EARLY_TERM_EN
        longint m;
        int bl;
        m = sm ? longint'($signed(b)) : longint'(b);
        if (m < 0) m = -m;
        bl = 0;
        while (m != 0) begin bl++; m = m >> 1; end
        if (bl < 1) bl = 1;
        return bl + 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (q_prod.size() == 0) begin
                checks++; failures++;
                $display("FAIL spurious_done: got done=1 product=%0h expected no pulse", product);
            end else begin
                logic [2*W-1:0] ep;
                int el, t0;
                ep = q_prod.pop_front();
                el = q_lat.pop_front();
                t0 = q_t0.pop_front();
                check("product", product, ep);
                // Driven at negedge cyc=t0, accept edge makes cyc=t0+1.
                check("latency", cyc - t0 - 1, el);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin @(negedge clk); n++; end
        if (!ready) begin
            checks++; failures++;
            $display("FAIL ready_timeout: got ready=0 expected 1");
        end
    endtask

    // Issue one op at a negedge while ready; returns at negedge after accept.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm, input logic [2*W-1:0] exp);
        wait_ready();
        word0 = a; word1 = b; signed_mode = sm; start = 1'b1;
        q_prod.push_back(exp);
        q_lat.push_back(ref_lat(b, sm));
        q_t0.push_back(cyc);
        @(negedge clk);
        start = 1'b0;
        word0 = $urandom; word1 = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_prod.size() != 0 || !ready) && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        check("drain_empty", q_prod.size(), 0);
    endtask

    initial begin
        int nlow;
        #1;
        check("rst_product", product, 0);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        do_op(4'hF, 4'hF, 1'b0, 8'hE1);
        nlow = 0;
        while (!ready && nlow < 50) begin nlow++; @(negedge clk); end
`ifndef ASMD_EARLY_TERM_EN
        check("ready_low_cycles", nlow, W + 1);
`endif
        repeat (3) @(negedge clk);
        check("product_held", product, 8'hE1);
        do_op(4'h0, 4'hD, 1'b0, 8'h00);
        do_op(4'h8, 4'h8, 1'b1, 8'h40);
        do_op(4'h8, 4'h7, 1'b1, 8'hC8);
        do_op(4'h7, 4'hF, 1'b1, 8'hF9);
        do_op(4'h8, 4'h7, 1'b0, 8'h38);
        do_op(4'hD, 4'h0, 1'b0, 8'h00);
        do_op(4'h9, 4'h1, 1'b0, 8'h09);
        do_op(4'h3, 4'h0, 1'b0, 8'h00);
        do_op(4'h1, 4'h8, 1'b0, 8'h08);
        drain();

        // Busy: second start two cycles after accept must be ignored.
        do_op(4'h6, 4'h5, 1'b0, 8'h1E);
        @(negedge clk);
        word0 = 4'h3; word1 = 4'h3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset mid-RUN: abort, product clears immediately, no pulse follows.
        do_op(4'h5, 4'h5, 1'b0, 8'h19);
        @(negedge clk);
        #2 reset = 1'b1;
        q_prod.delete(); q_lat.delete(); q_t0.delete();
        #1;
        check("midrun_rst_product", product, 0);
        check("midrun_rst_ready", ready, 1);
        check("midrun_rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_product", product, 0);

        // Random back-to-back ops vs reference model.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a, b;
            logic sm;
            a = W'($urandom); b = W'($urandom); sm = 1'($urandom);
            do_op(a, b, sm, ref_mul(a, b, sm));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
